// File: rtl/exit_report_pkg.sv
// exit_report_pkg: shared state encoding, frame layout and ASCII helpers for the exit reporter.
package exit_report_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} report_state_e;
  localparam int FRAME_LEN = 15;
  localparam logic [7:0] PREFIX [5] = '{8'h45, 8'h58, 8'h49, 8'h54, 8'h3D};
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  // idx 0-4 prefix, 5-12 hex digits MSB nibble first, 13 CR, 14 LF
  function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [31:0] v);
    logic [31:0] sh;
    sh = v >> {4'd12 - idx, 2'b00};
    return (idx < 4'd5) ? PREFIX[idx[2:0]] :
           (idx < 4'd13) ? hex2ascii(sh[3:0]) :
           (idx == 4'd13) ? 8'h0D : 8'h0A;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; ready rises in the last stop-bit cycle so chars chain gap-free.
module uart_tx_byte
  import exit_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  report_state_e state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic bit_end, load, shift;
  always_comb begin
    bit_end = baud_cnt_q == LAST;
    ready_o = (state_q == IDLE) || (state_q == STOP && bit_end);
    load = valid_i && ready_o;
    shift = state_q == DATA && bit_end;
    baud_cnt_d = (load || state_q == IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d = load ? 3'd0 : shift ? bit_idx_q + 3'd1 : bit_idx_q;
    shreg_d = load ? data_i : shift ? shreg_q >> 1 : shreg_q;
    state_d = state_q;
    if (load) state_d = START;
    else if (bit_end)
      case (state_q)
        START:   state_d = DATA;
        DATA:    state_d = (bit_idx_q == 3'd7) ? STOP : DATA;
        default: state_d = IDLE;
      endcase
    tx_o = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[0] : 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q <= shreg_d;
    end
  end
endmodule

// File: rtl/exit_status_uart_reporter.sv
// exit_status_uart_reporter: latches the SoC exit code on a valid edge, reports it as
// "EXIT=XXXXXXXX\r\n" on a debug UART and drives pass/fail LEDs.
module exit_status_uart_reporter
  import exit_report_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_led_o,
  output logic        fail_led_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [3:0] LAST_CHAR = 4'(FRAME_LEN - 1);
  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least 2");
  end
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] value_q, value_d;
  logic [3:0] char_idx_q, char_idx_d;
  logic start, tx_valid, tx_ready, char_end;
  logic [7:0] tx_data;
  always_comb begin
    start = exit_valid_i && !valid_q && !busy_q;
    char_end = busy_q && tx_ready;
    valid_d = exit_valid_i;
    value_d = start ? exit_value_i : value_q;
    tx_valid = start || (busy_q && char_idx_q != LAST_CHAR);
    tx_data = frame_char(start ? 4'd0 : char_idx_q + 4'd1, value_q);
    char_idx_d = start ? 4'd0 : (char_end && char_idx_q != LAST_CHAR) ? char_idx_q + 4'd1 : char_idx_q;
    busy_d = start || (busy_q && !(char_end && char_idx_q == LAST_CHAR));
    done_d = !start && (done_q || (char_end && char_idx_q == LAST_CHAR));
    busy_o = busy_q;
    done_o = done_q;
    pass_led_o = done_q && value_q == 32'd0;
    fail_led_o = done_q && value_q != 32'd0;
  end
  // valid_q resets high: a level already asserted across reset is not a new exit event
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      value_q <= '0;
      char_idx_q <= '0;
    end else begin
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      value_q <= value_d;
      char_idx_q <= char_idx_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (tx_valid),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .tx_o    (tx_o)
  );
endmodule

// File: tb/tb_exit_status_uart_reporter.sv
// tb_exit_status_uart_reporter: random and directed stimulus against a frame-level model plus a UART decoder.
module tb_exit_status_uart_reporter;
  localparam int CPB = 4;
  localparam int FRAME_CYC = 150 * CPB;
  logic clk_i = 0, rst_ni = 0, exit_valid_i = 0;
  logic [31:0] exit_value_i = 0;
  logic tx_o, busy_o, done_o, pass_led_o, fail_led_o;
  int checks = 0, errors = 0, shown = 0, cyc_n = 0;
  always #5 clk_i = ~clk_i;
  exit_status_uart_reporter #(.CLK_FREQ_HZ(400), .BAUD_RATE(100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .pass_led_o(pass_led_o), .fail_led_o(fail_led_o)
  );
  function automatic string frame_str(input logic [31:0] v);
    string hx, s;
    hx = "0123456789ABCDEF";
    s = "EXIT=";
    for (int i = 7; i >= 0; i--) begin
      int n;
      n = int'(v[4*i +: 4]);
      s = {s, hx.substr(n, n)};
    end
    return {s, "\015\012"};
  endfunction
  // frame-level model: a frame is the bit string of frame_str, started on an accepted edge
  logic m_prev = 1, m_busy = 0, m_done = 0;
  logic [31:0] m_val = 0;
  int m_pos = 0;
  string m_str = "";
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_prev = 1; m_busy = 0; m_done = 0; m_val = 0; m_pos = 0;
    end else begin
      if (m_busy) begin
        m_pos++;
        if (m_pos == FRAME_CYC) begin m_busy = 0; m_done = 1; end
      end else if (exit_valid_i && !m_prev) begin
        m_val = exit_value_i; m_busy = 1; m_done = 0; m_pos = 0; m_str = frame_str(exit_value_i);
      end
      m_prev = exit_valid_i;
    end
  end
  always @(negedge clk_i) begin
    logic e_tx;
    byte ch;
    int k;
    e_tx = 1;
    if (m_busy) begin
      k = m_pos / CPB;
      ch = m_str[k / 10];
      e_tx = (k % 10 == 0) ? 1'b0 : (k % 10 == 9) ? 1'b1 : ch[k % 10 - 1];
    end
    cyc_n++;
    checks++;
    if ({tx_o, busy_o, done_o, pass_led_o, fail_led_o} !==
        {e_tx, m_busy, m_done, m_done && m_val == 0, m_done && m_val != 0}) begin
      errors++;
      if (shown < 20)
        $display("FAIL cycle%0d tx/busy/done/pass/fail actual=%b%b%b%b%b expected=%b%b%b%b%b", cyc_n,
                 tx_o, busy_o, done_o, pass_led_o, fail_led_o,
                 e_tx, m_busy, m_done, m_done && m_val == 0, m_done && m_val != 0);
      shown++;
    end
  end
  int rx_off = -1, busy_cyc = 0, frames = 0;
  logic [7:0] rx_byte = 0;
  logic busy_prev = 0;
  string rx_str = "";
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      rx_off = -1; busy_prev = 0;
    end else begin
      if (rx_off < 0) begin
        if (tx_o == 1'b0) rx_off = 0;
      end else begin
        rx_off++;
        if (rx_off % CPB == CPB / 2 && rx_off / CPB >= 1 && rx_off / CPB <= 8) rx_byte[rx_off / CPB - 1] = tx_o;
        if (rx_off == 10 * CPB - 1) begin rx_str = $sformatf("%s%c", rx_str, rx_byte); rx_off = -1; end
      end
      if (busy_o && !busy_prev) begin frames++; busy_cyc = 0; end
      if (busy_o) busy_cyc++;
      busy_prev = busy_o;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s actual=%0h expected=%0h", name, act, exp); end
  endtask
  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s actual=\"%s\" expected=\"%s\"", name, act, exp); end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy_o && i < 2 * FRAME_CYC) begin @(negedge clk_i); i++; end
    checks++;
    if (busy_o) begin errors++; $display("FAIL %s timeout busy actual=1 expected=0", name); end
    cyc(1);
  endtask
  initial begin
    int f0;
    cyc(3); rst_ni = 1; cyc(100);
    check("rst_tx", tx_o, 1); check("rst_busy", busy_o, 0); check("rst_done", done_o, 0);
    check("rst_pass", pass_led_o, 0); check("rst_fail", fail_led_o, 0);
    rx_str = ""; exit_value_i = 32'h0; exit_valid_i = 1; cyc(1);
    check("start_bit", tx_o, 0); check("busy_t1", busy_o, 1);
    wait_idle("frame0");
    check_str("frame0", rx_str, "EXIT=00000000\015\012");
    check("busy_len", busy_cyc, 600); check("done0", done_o, 1);
    check("pass0", pass_led_o, 1); check("fail0", fail_led_o, 0);
    exit_valid_i = 0; cyc(2);
    rx_str = ""; exit_value_i = 32'hDEADBEEF; exit_valid_i = 1; cyc(200);
    exit_valid_i = 0; exit_value_i = 32'h1; cyc(3); exit_valid_i = 1; cyc(3);
    check("busy_ignored", busy_o, 1);
    wait_idle("frame_dead");
    check_str("frame_dead", rx_str, "EXIT=DEADBEEF\015\012");
    check("fail_dead", fail_led_o, 1); check("pass_dead", pass_led_o, 0);
    exit_valid_i = 0; cyc(1); rx_str = ""; exit_value_i = 32'hA; exit_valid_i = 1; cyc(1);
    check("done_cleared", done_o, 0);
    wait_idle("frame_a");
    check_str("frame_a", rx_str, "EXIT=0000000A\015\012");
    check("fail_a", fail_led_o, 1);
    exit_valid_i = 0; cyc(2);
    exit_value_i = 32'h12345678; exit_valid_i = 1; cyc(1);
    cyc(7 * 10 * CPB + 4 * CPB);
    #1 rst_ni = 0;
    #1 check("async_tx", tx_o, 1); check("async_busy", busy_o, 0);
    cyc(3); rst_ni = 1; f0 = frames; cyc(1000);
    check("no_frame_after_rst", frames, f0); check("idle_after_rst", busy_o, 0);
    exit_valid_i = 0; cyc(2); f0 = frames; exit_value_i = 32'h0; exit_valid_i = 1; cyc(3000);
    check("one_frame", frames, f0 + 1); check("held_tx", tx_o, 1); check("held_pass", pass_led_o, 1);
    exit_valid_i = 0;
    repeat (10) begin
      cyc($urandom_range(1, 5));
      exit_value_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      exit_valid_i = 1;
      cyc($urandom_range(1, 900));
      exit_valid_i = 0;
    end
    cyc(FRAME_CYC + 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
